// File: rtl/cq_viola_ipl_pkg.sv
// Shared constants and types for the IPL boot-RAM arbiter slice.
package cq_viola_ipl_pkg;

  localparam int unsigned IPL_ADDR_W = 11;
  localparam int unsigned IPL_DATA_W = 32;

  localparam int unsigned PORT_CPU  = 0;
  localparam int unsigned PORT_HOST = 1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } ipl_state_t;

  // A slave port requests when selected with either command; read+write is a write.
  function automatic logic port_req(input logic cs, input logic rd, input logic wr);
    return cs & (rd | wr);
  endfunction

endpackage

// File: rtl/cq_viola_ipl_rrarb.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that was not granted last. last_grant resets to 1 so port 0 wins the first tie.
module cq_viola_ipl_rrarb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/cq_viola_ipl_arbiter.sv
// Two-port Avalon-MM arbiter in front of the single-port IPL boot RAM.
// Optional feature macro: CQ_VIOLA_IPL_WRLOCK_EN adds a wrlock input that squashes port-0 writes.
module cq_viola_ipl_arbiter
  import cq_viola_ipl_pkg::*;
#(
  parameter int unsigned ADDR_W = IPL_ADDR_W,
  parameter int unsigned DATA_W = IPL_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                reset_req,
`ifdef CQ_VIOLA_IPL_WRLOCK_EN
  input  logic                wrlock,
`endif
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic                s0_chipselect,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  input  logic [DATA_W-1:0]   s0_writedata,
  output logic                s0_waitrequest,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic                s0_readdatavalid,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  ipl_state_t state, cur_state, state_nxt;
  logic       init_cnt, init_cnt_nxt;
  logic       run;

  logic [1:0]        req, gnt;
  logic              gnt_any, sel;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic              sel_wr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              wr_block;
  logic              rd_accept;
  logic              rd_pend, rd_owner;

  // The RUN<->HOLD transitions take effect in the same cycle reset_req changes,
  // so grants stop on the first reset_req cycle and resume on the first clear one.
  always_comb begin
    cur_state    = state;
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    if (state == ST_RUN && reset_req) begin
      cur_state = ST_HOLD;
    end else if (state == ST_HOLD && !reset_req) begin
      cur_state = ST_RUN;
    end
    unique case (cur_state)
      ST_INIT: begin
        init_cnt_nxt = 1'b1;
        if (init_cnt) begin
          state_nxt    = ST_RUN;
          init_cnt_nxt = 1'b0;
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      ST_HOLD: state_nxt = ST_HOLD;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  assign run       = (cur_state == ST_RUN) && !reset_req;
  assign mem_clken = run;

  assign req[PORT_CPU]  = port_req(s0_chipselect, s0_read, s0_write);
  assign req[PORT_HOST] = port_req(s1_chipselect, s1_read, s1_write);

  cq_viola_ipl_rrarb u_rrarb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run),
    .req     (req),
    .gnt     (gnt)
  );

  assign gnt_any = |gnt;
  assign sel     = gnt[PORT_HOST];

  assign s0_waitrequest = ~gnt[PORT_CPU];
  assign s1_waitrequest = ~gnt[PORT_HOST];

  always_comb begin
    sel_addr  = s0_address;
    sel_wr    = s0_write;
    sel_be    = s0_byteenable;
    sel_wdata = s0_writedata;
    if (sel) begin
      sel_addr  = s1_address;
      sel_wr    = s1_write;
      sel_be    = s1_byteenable;
      sel_wdata = s1_writedata;
    end
  end

`ifdef CQ_VIOLA_IPL_WRLOCK_EN
  assign wr_block = wrlock & gnt[PORT_CPU] & s0_write;
`else
  assign wr_block = 1'b0;
`endif

  assign rd_accept = gnt_any & ~sel_wr;

  always_comb begin
    mem_chipselect = gnt_any & ~wr_block;
    mem_write      = gnt_any & sel_wr & ~wr_block;
    mem_address    = gnt_any ? sel_addr : addr_q;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (gnt_any) begin
      mem_byteenable = sel_wr ? sel_be : '1;
      if (sel_wr) begin
        mem_writedata = sel_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= rd_accept;
      if (gnt_any) begin
        addr_q <= sel_addr;
      end
      if (rd_accept) begin
        rd_owner <= sel;
      end
    end
  end

  assign s0_readdatavalid = rd_pend & ~rd_owner;
  assign s1_readdatavalid = rd_pend &  rd_owner;
  assign s0_readdata      = s0_readdatavalid ? mem_readdata : '0;
  assign s1_readdata      = s1_readdatavalid ? mem_readdata : '0;

endmodule
